// File: rtl/input_io_bank_pkg.sv
// Shared constants and helpers for the input IO bank: mode names and a
// constant-foldable ceiling log2 used to size the per-channel filter counters.
package input_io_bank_pkg;

   localparam string MODE_BUFF = "in_buff";
   localparam string MODE_REG  = "in_reg";
   localparam string MODE_SYNC = "in_sync";
   localparam string MODE_FILT = "in_filt";

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/io_chan_filter.sv
// One input channel: synchroniser chain, optional glitch-filter counter and
// registered rise/fall pulse generation alongside the conditioned output.
module io_chan_filter
   import input_io_bank_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILT_LEN    = 4,
   parameter bit   USE_FILT    = 1'b1,
   parameter logic RST_BIT     = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_din,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   // Without the filter the last synchroniser stage is the enabled output itself.
   localparam int N_SYNC = USE_FILT ? SYNC_STAGES : SYNC_STAGES - 1;
   localparam int CW     = clog2(FILT_LEN);
   localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

   logic [N_SYNC-1:0] r_sync;
   logic [CW-1:0]     r_cnt;
   logic              r_q;
   logic              r_rise;
   logic              r_fall;
   logic [CW-1:0]     w_cnt_next;
   logic              w_q_next;
   logic              w_s;

   assign w_s = r_sync[N_SYNC-1];

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch is inferred.
      w_q_next   = r_q;
      w_cnt_next = r_cnt;
      if (USE_FILT) begin
         if (w_s == r_q) begin
            w_cnt_next = '0;
         end else if (r_cnt != CNT_MAX) begin
            w_cnt_next = r_cnt + CW'(1);
         end else if (i_en) begin
            w_q_next   = w_s;
            w_cnt_next = '0;
         end
      end else if (i_en) begin
         w_q_next = w_s;
      end
   end

   // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= {N_SYNC{RST_BIT}};
         r_q    <= RST_BIT;
         r_cnt  <= '0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync[0] <= i_din;
         for (int k = 1; k < N_SYNC; k++) begin
            r_sync[k] <= r_sync[k-1];
         end
         r_q    <= w_q_next;
         r_cnt  <= w_cnt_next;
         r_rise <= ~r_q & w_q_next;
         r_fall <= r_q & ~w_q_next;
      end
   end

   assign o_q    = r_q;
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/input_io_bank.sv
// Multi-channel input cell: delivers pad inputs to the fabric through a buffer,
// enabled register, synchroniser or synchroniser+glitch filter, with edge pulses.
(* whitebox, FASM_PARAMS = "MODE;SYNC_STAGES;FILT_LEN;RST_VAL", MODES = "in_buff;in_reg;in_sync;in_filt" *)
module input_io_bank
   import input_io_bank_pkg::*;
#(
   parameter int               WIDTH       = 4,
   parameter string            MODE        = "in_reg",
   parameter int               SYNC_STAGES = 2,
   parameter int               FILT_LEN    = 4,
   parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}}
) (
   input  logic             IQC,
   input  logic             QRT,
   input  logic             IQE,
   input  logic [WIDTH-1:0] A2F,
   output logic [WIDTH-1:0] IQZ,
   output logic [WIDTH-1:0] IQR,
   output logic [WIDTH-1:0] IQF
);

   localparam bit IS_BUFF = (MODE == MODE_BUFF);
   localparam bit IS_REG  = (MODE == MODE_REG);
   localparam bit IS_SYNC = (MODE == MODE_SYNC);
   localparam bit IS_FILT = (MODE == MODE_FILT);

   generate
      if (!(IS_BUFF || IS_REG || IS_SYNC || IS_FILT)) begin : g_bad_mode
         $error("input_io_bank: unsupported MODE %s", MODE);
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("input_io_bank: SYNC_STAGES must be at least 2");
      end
      if (FILT_LEN < 2) begin : g_bad_filt
         $error("input_io_bank: FILT_LEN must be at least 2");
      end

      if (IS_BUFF) begin : g_buff
         assign IQZ = A2F;
         assign IQR = '0;
         assign IQF = '0;
      end else if (IS_REG) begin : g_reg
         logic [WIDTH-1:0] r_q;
         logic [WIDTH-1:0] r_rise;
         logic [WIDTH-1:0] r_fall;

         always_ff @(posedge IQC) begin
            if (QRT) begin
               r_q    <= RST_VAL;
               r_rise <= '0;
               r_fall <= '0;
            end else if (IQE) begin
               r_q    <= A2F;
               r_rise <= ~r_q & A2F;
               r_fall <= r_q & ~A2F;
            end else begin
               r_rise <= '0;
               r_fall <= '0;
            end
         end

         assign IQZ = r_q;
         assign IQR = r_rise;
         assign IQF = r_fall;
      end else begin : g_chan
         for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            io_chan_filter #(
               .SYNC_STAGES (SYNC_STAGES),
               .FILT_LEN    (FILT_LEN),
               .USE_FILT    (IS_FILT),
               .RST_BIT     (RST_VAL[i])
            ) u_chan (
               .i_clk  (IQC),
               .i_rst  (QRT),
               .i_en   (IQE),
               .i_din  (A2F[i]),
               .o_q    (IQZ[i]),
               .o_rise (IQR[i]),
               .o_fall (IQF[i])
            );
         end
      end
   endgenerate

endmodule
